// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, branch-operand
// and HI/LO hazards, mult/div busy tracking, and the two-cycle exception/ERET flush.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             rs_use_ID,
  input  logic             rt_use_ID,
  input  logic             branch_ID,
  input  logic             HiLo_ID,
  input  logic [4:0]       A3_EX,
  input  logic             GprWrite_EX,
  input  logic             Mem2Gpr_EX,
  input  logic             mnd_EX,
  input  logic [1:0]       mndop_EX,
  input  logic [4:0]       A3_MEM,
  input  logic             Mem2Gpr_MEM,
  input  logic             Exception_MEM,
  input  logic             is_eret_MEM,
  output logic             En_PC,
  output logic             En_ID,
  output logic             Clr_ID,
  output logic             Clr_EX,
  output logic             Clr_MEM,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0]       MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0]       DIV_LD  = 4'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [3:0] md_cnt;

  logic match_ex, match_mem;
  logic lu, br, md, stall, flush_req, take_stall;

  // Only the DIV/MULT distinction matters for latency; signedness is irrelevant here.
  logic unused_mndop;
  assign unused_mndop = mndop_EX[0];

  // $0 is hard-wired to zero, so it can never be a true dependency.
  assign match_ex  = (A3_EX != 5'd0) &&
                     ((rs_use_ID && (rs_ID == A3_EX)) || (rt_use_ID && (rt_ID == A3_EX)));
  assign match_mem = (A3_MEM != 5'd0) &&
                     ((rs_use_ID && (rs_ID == A3_MEM)) || (rt_use_ID && (rt_ID == A3_MEM)));

  assign md_busy    = (md_cnt != 4'd0);
  assign lu         = Mem2Gpr_EX & match_ex;
  assign br         = branch_ID & ((GprWrite_EX & match_ex) | (Mem2Gpr_MEM & match_mem));
  assign md         = HiLo_ID & (md_busy | mnd_EX);
  assign stall      = lu | br | md;
  assign flush_req  = Exception_MEM | is_eret_MEM;
  assign take_stall = (state == RUN) && !flush_req && stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= RUN;
      md_cnt    <= 4'd0;
      stall_cnt <= '0;
    end else begin
      // A flush request in either state (re)starts the one-cycle FLUSH follow-up.
      state <= flush_req ? FLUSH : RUN;

      // Flushes leave md_cnt alone: the in-flight operation still writes HI/LO.
      if (mnd_EX && (md_cnt == 4'd0))
        md_cnt <= mndop_EX[1] ? DIV_LD : MULT_LD;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;

      if (take_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves one unassigned and infers a latch.
  always_comb begin
    En_PC   = 1'b1;
    En_ID   = 1'b1;
    Clr_ID  = 1'b0;
    Clr_EX  = 1'b0;
    Clr_MEM = 1'b0;
    if (!Reset_n) begin
      En_PC   = 1'b0;
      En_ID   = 1'b0;
      Clr_ID  = 1'b1;
      Clr_EX  = 1'b1;
      Clr_MEM = 1'b1;
    end else if (flush_req) begin
      // PC loads the exception vector or EPC while everything younger is squashed.
      Clr_ID  = 1'b1;
      Clr_EX  = 1'b1;
      Clr_MEM = 1'b1;
    end else if (state == FLUSH) begin
      Clr_ID  = 1'b1;
    end else if (stall) begin
      En_PC   = 1'b0;
      En_ID   = 1'b0;
      Clr_EX  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int MULTC   = 5;
  localparam int DIVC    = 10;

  // {En_PC, En_ID, Clr_ID, Clr_EX, Clr_MEM}
  typedef logic [4:0] strobe_t;
  localparam strobe_t S_RUN   = 5'b11000;
  localparam strobe_t S_STALL = 5'b00010;
  localparam strobe_t S_FLUSH = 5'b11111;
  localparam strobe_t S_FL2   = 5'b11100;
  localparam strobe_t S_RST   = 5'b00111;

  typedef struct {
    logic [4:0] rs, rt;
    logic       rs_use, rt_use, branch, hilo;
    logic [4:0] a3_ex;
    logic       gw_ex, m2g_ex, mnd;
    logic [1:0] mndop;
    logic [4:0] a3_mem;
    logic       m2g_mem, exc, eret;
  } in_t;

  typedef struct {
    strobe_t       s;
    logic          busy;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct {
    in_t     i;
    strobe_t e;
    string   name;
  } vec_t;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [4:0]    rs_ID, rt_ID, A3_EX, A3_MEM;
  logic          rs_use_ID, rt_use_ID, branch_ID, HiLo_ID;
  logic          GprWrite_EX, Mem2Gpr_EX, mnd_EX, Mem2Gpr_MEM, Exception_MEM, is_eret_MEM;
  logic [1:0]    mndop_EX;
  logic          En_PC, En_ID, Clr_ID, Clr_EX, Clr_MEM, md_busy;
  logic [CW-1:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  // Behavioural model state: flush follow-up pending, remaining busy cycles, stall count.
  bit m_flush;
  int m_busy;
  int m_cnt;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID),
    .branch_ID(branch_ID), .HiLo_ID(HiLo_ID),
    .A3_EX(A3_EX), .GprWrite_EX(GprWrite_EX), .Mem2Gpr_EX(Mem2Gpr_EX),
    .mnd_EX(mnd_EX), .mndop_EX(mndop_EX),
    .A3_MEM(A3_MEM), .Mem2Gpr_MEM(Mem2Gpr_MEM),
    .Exception_MEM(Exception_MEM), .is_eret_MEM(is_eret_MEM),
    .En_PC(En_PC), .En_ID(En_ID), .Clr_ID(Clr_ID), .Clr_EX(Clr_EX), .Clr_MEM(Clr_MEM),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic bit reads(input in_t v, input logic [4:0] r);
    return (r != 0) && ((v.rs_use && v.rs == r) || (v.rt_use && v.rt == r));
  endfunction

  function automatic bit hazard(input in_t v);
    bit load_use, branch_dep, hilo_dep;
    load_use   = v.m2g_ex && reads(v, v.a3_ex);
    branch_dep = v.branch && ((v.gw_ex && reads(v, v.a3_ex)) || (v.m2g_mem && reads(v, v.a3_mem)));
    hilo_dep   = v.hilo && (m_busy > 0 || v.mnd);
    return load_use || branch_dep || hilo_dep;
  endfunction

  function automatic strobe_t model_strobes(input in_t v);
    if (v.exc || v.eret) return S_FLUSH;
    if (m_flush)         return S_FL2;
    if (hazard(v))       return S_STALL;
    return S_RUN;
  endfunction

  function automatic void model_step(input in_t v);
    bit fl, hz;
    fl = v.exc || v.eret;
    hz = hazard(v);
    if (!m_flush && !fl && hz && m_cnt < CNT_MAX) m_cnt++;
    if (v.mnd && m_busy == 0) m_busy = v.mndop[1] ? DIVC : MULTC;
    else if (m_busy > 0)      m_busy--;
    m_flush = fl;
  endfunction

  function automatic void model_reset();
    m_flush = 0;
    m_busy  = 0;
    m_cnt   = 0;
  endfunction

  task automatic drive(input in_t v);
    rs_ID = v.rs;  rt_ID = v.rt;  rs_use_ID = v.rs_use;  rt_use_ID = v.rt_use;
    branch_ID = v.branch;  HiLo_ID = v.hilo;
    A3_EX = v.a3_ex;  GprWrite_EX = v.gw_ex;  Mem2Gpr_EX = v.m2g_ex;
    mnd_EX = v.mnd;  mndop_EX = v.mndop;
    A3_MEM = v.a3_mem;  Mem2Gpr_MEM = v.m2g_mem;
    Exception_MEM = v.exc;  is_eret_MEM = v.eret;
  endtask

  function automatic out_t sample();
    out_t o;
    o.s    = {En_PC, En_ID, Clr_ID, Clr_EX, Clr_MEM};
    o.busy = md_busy;
    o.cnt  = stall_cnt;
    return o;
  endfunction

  // One clock cycle: apply inputs, sample mid-cycle, advance the model, pass the edge.
  task automatic tick(input in_t v, output out_t o, output strobe_t es,
                      output logic eb, output int ec);
    drive(v);
    @(negedge Clk);
    o  = sample();
    es = model_strobes(v);
    eb = (m_busy > 0);
    ec = m_cnt;
    model_step(v);
    @(posedge Clk);
    #1;
  endtask

  task automatic run_cycle(input in_t v, input string name);
    out_t o; strobe_t es; logic eb; int ec;
    tick(v, o, es, eb, ec);
    check({name, ".strobes"}, 32'(o.s), 32'(es));
    check({name, ".md_busy"}, 32'(o.busy), 32'(eb));
    check({name, ".stall_cnt"}, 32'(o.cnt), 32'(ec));
  endtask

  task automatic md_sequence(input logic [1:0] op, input int exp_stalls, input int exp_busy,
                             input string name);
    in_t v; out_t o; strobe_t es; logic eb; int ec;
    int stalls, busy_cycles;
    bit released;
    v = idle(); v.mnd = 1'b1; v.mndop = op; v.hilo = 1'b1;
    tick(v, o, es, eb, ec);
    check({name, ".first_stall"}, 32'(o.s), 32'(S_STALL));
    stalls = (o.s == S_STALL) ? 1 : 0;
    busy_cycles = 0;
    released = 0;
    v.mnd = 1'b0;
    for (int n = 0; n < 30 && !released; n++) begin
      tick(v, o, es, eb, ec);
      if (o.busy) busy_cycles++;
      if (o.s[4]) released = 1;
      else        stalls++;
    end
    check({name, ".released"}, 32'(released), 32'd1);
    check({name, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({name, ".busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
  endtask

  vec_t tv[11];

  initial begin
    in_t v; out_t o; strobe_t es; logic eb; int ec;

    // Directed single-cycle vectors, all applied from RUN with the mult/div unit idle.
    for (int k = 0; k < 11; k++) tv[k].i = idle();
    tv[0].i.rs = 8; tv[0].i.rs_use = 1; tv[0].i.a3_ex = 8; tv[0].i.m2g_ex = 1;
    tv[0].e = S_STALL; tv[0].name = "lu_rs";
    tv[1].i.rs = 0; tv[1].i.rs_use = 1; tv[1].i.a3_ex = 0; tv[1].i.m2g_ex = 1;
    tv[1].e = S_RUN;   tv[1].name = "lu_r0";
    tv[2].i.rt = 12; tv[2].i.rt_use = 1; tv[2].i.a3_ex = 12; tv[2].i.m2g_ex = 1;
    tv[2].e = S_STALL; tv[2].name = "lu_rt";
    tv[3].i.rt = 12; tv[3].i.rt_use = 0; tv[3].i.a3_ex = 12; tv[3].i.m2g_ex = 1;
    tv[3].e = S_RUN;   tv[3].name = "lu_rt_unused";
    tv[4].i.rs = 8; tv[4].i.rs_use = 1; tv[4].i.a3_ex = 9; tv[4].i.m2g_ex = 1;
    tv[4].e = S_RUN;   tv[4].name = "lu_nomatch";
    tv[5].i.rs = 5; tv[5].i.rs_use = 1; tv[5].i.branch = 1; tv[5].i.a3_ex = 5; tv[5].i.gw_ex = 1;
    tv[5].e = S_STALL; tv[5].name = "br_ex";
    tv[6].i.rt = 5; tv[6].i.rt_use = 1; tv[6].i.branch = 1; tv[6].i.a3_mem = 5; tv[6].i.m2g_mem = 1;
    tv[6].e = S_STALL; tv[6].name = "br_mem_load";
    tv[7].i.rs = 5; tv[7].i.rs_use = 1; tv[7].i.a3_ex = 5; tv[7].i.gw_ex = 1;
    tv[7].e = S_RUN;   tv[7].name = "alu_fwd_ex";
    tv[8].i.rs = 5; tv[8].i.rs_use = 1; tv[8].i.a3_mem = 5; tv[8].i.m2g_mem = 1;
    tv[8].e = S_RUN;   tv[8].name = "alu_fwd_mem";
    tv[9].i.hilo = 1;
    tv[9].e = S_RUN;   tv[9].name = "hilo_idle";
    tv[10].i.rs = 0; tv[10].i.rs_use = 1; tv[10].i.branch = 1; tv[10].i.a3_ex = 0; tv[10].i.gw_ex = 1;
    tv[10].e = S_RUN;  tv[10].name = "br_r0";

    // Reset is asynchronous: outputs must be at reset values before any edge.
    Reset_n = 1'b0;
    drive(idle());
    model_reset();
    #1;
    check("reset.strobes", 32'({En_PC, En_ID, Clr_ID, Clr_EX, Clr_MEM}), 32'(S_RST));
    check("reset.md_busy", 32'(md_busy), 32'd0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int k = 0; k < 11; k++) begin
      tick(tv[k].i, o, es, eb, ec);
      check({tv[k].name, ".strobes"}, 32'(o.s), 32'(tv[k].e));
      check({tv[k].name, ".stall_cnt"}, 32'(o.cnt), 32'(ec));
    end
    check("table.stall_cnt_total", 32'(stall_cnt), 32'd4);

    // Exception while a load-use stall is pending: flush wins and is not counted.
    v = idle(); v.rs = 8; v.rs_use = 1; v.a3_ex = 8; v.m2g_ex = 1; v.exc = 1;
    tick(v, o, es, eb, ec);
    check("exc_stall.flush", 32'(o.s), 32'(S_FLUSH));
    v.exc = 0;
    tick(v, o, es, eb, ec);
    check("exc_stall.flush2", 32'(o.s), 32'(S_FL2));
    tick(idle(), o, es, eb, ec);
    check("exc_stall.run", 32'(o.s), 32'(S_RUN));
    check("exc_stall.no_count", 32'(stall_cnt), 32'd4);

    // ERET in MEM on consecutive cycles keeps the controller in FLUSH one more cycle.
    v = idle(); v.eret = 1;
    tick(v, o, es, eb, ec);
    check("b2b.flush_a", 32'(o.s), 32'(S_FLUSH));
    tick(v, o, es, eb, ec);
    check("b2b.flush_b", 32'(o.s), 32'(S_FLUSH));
    v.eret = 0;
    tick(v, o, es, eb, ec);
    check("b2b.flush2", 32'(o.s), 32'(S_FL2));
    tick(v, o, es, eb, ec);
    check("b2b.run", 32'(o.s), 32'(S_RUN));

    md_sequence(2'b10, DIVC + 1, DIVC, "div");
    md_sequence(2'b00, MULTC + 1, MULTC, "mult");
    // 4 + 11 + 6 stall cycles exceed the 4-bit range.
    check("stall_cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));

    // Reset in the middle of a divide, away from any clock edge.
    v = idle(); v.mnd = 1; v.mndop = 2'b11;
    tick(v, o, es, eb, ec);
    repeat (4) tick(idle(), o, es, eb, ec);
    check("rst_mid_div.busy_before", 32'(md_busy), 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    check("rst_mid_div.strobes", 32'({En_PC, En_ID, Clr_ID, Clr_EX, Clr_MEM}), 32'(S_RST));
    check("rst_mid_div.md_busy", 32'(md_busy), 32'd0);
    check("rst_mid_div.stall_cnt", 32'(stall_cnt), 32'd0);
    #3 Reset_n = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
    tick(idle(), o, es, eb, ec);
    check("rst_release.run", 32'(o.s), 32'(S_RUN));
    check("rst_release.md_busy", 32'(o.busy), 32'd0);

    // Randomized traffic; mult/div only issued when the model says the unit is idle.
    for (int n = 0; n < 400; n++) begin
      v = idle();
      v.rs      = 5'($urandom_range(0, 3));
      v.rt      = 5'($urandom_range(0, 3));
      v.rs_use  = 1'($urandom_range(0, 1));
      v.rt_use  = 1'($urandom_range(0, 1));
      v.branch  = ($urandom_range(0, 3) == 0);
      v.hilo    = ($urandom_range(0, 3) == 0);
      v.a3_ex   = 5'($urandom_range(0, 3));
      v.gw_ex   = 1'($urandom_range(0, 1));
      v.m2g_ex  = ($urandom_range(0, 3) == 0);
      v.mnd     = (m_busy == 0) && ($urandom_range(0, 7) == 0);
      v.mndop   = 2'($urandom_range(0, 3));
      v.a3_mem  = 5'($urandom_range(0, 3));
      v.m2g_mem = 1'($urandom_range(0, 1));
      v.exc     = ($urandom_range(0, 15) == 0);
      v.eret    = ($urandom_range(0, 15) == 0);
      run_cycle(v, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
